// File: rtl/truth_table_sweep.sv
// Truth-table store with 1-cycle evaluate port and an exhaustive ones/zeros sweep.
// Latency: evaluate 1 cycle; done pulses DEPTH+1 cycles after sweep start.
// Backpressure: none; loads are ignored while sweeping, and a start that is not accepted is dropped.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   load_en, load_bit     - serial table load at an auto-incrementing pointer
//   eval_valid, eval_in   - evaluate request; MSB of eval_in is the first variable
//   t_valid, t_out        - registered evaluate result
//   sweep_start           - begin counting ones/zeros over the whole table
//   busy, done            - sweep in progress / one-cycle completion pulse
//   ones_cnt, zeros_cnt   - sweep results, held until the next sweep starts
//   tt_loaded             - sticky: every entry has been written at least once
module truth_table_sweep #(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            load_bit,
  input  logic            eval_valid,
  input  logic [N_IN-1:0] eval_in,
  output logic            t_valid,
  output logic            t_out,
  input  logic            sweep_start,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_cnt,
  output logic [N_IN:0]   zeros_cnt,
  output logic            tt_loaded
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN-1:0] IDX_ONE  = 1;
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
  localparam logic [N_IN:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [DEPTH-1:0]  tt;
  logic [N_IN-1:0]   load_ptr;
  logic [N_IN-1:0]   sweep_idx;
  logic              start_ok;
  logic              load_ok;

  // A start is only honoured outside SWEEP with a fully written table.
  assign start_ok = sweep_start && tt_loaded && (state != ST_SWEEP);
  // An accepted start wins over a same-cycle load, so the counted table is stable.
  assign load_ok  = load_en && (state != ST_SWEEP) && !start_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tt        <= '0;
      load_ptr  <= '0;
      sweep_idx <= '0;
      tt_loaded <= 1'b0;
      t_valid   <= 1'b0;
      t_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ones_cnt  <= '0;
      zeros_cnt <= '0;
    end else begin
      // Evaluate runs in every state; the read uses the pre-edge table contents,
      // so a same-cycle write to the same index returns the old value.
      t_valid <= eval_valid;
      if (eval_valid) begin
        t_out <= tt[eval_in];
      end

      if (load_ok) begin
        tt[load_ptr] <= load_bit;
        load_ptr     <= load_ptr + IDX_ONE;
        if (load_ptr == IDX_LAST) begin
          tt_loaded <= 1'b1;
        end
      end

      done <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state     <= ST_SWEEP;
            busy      <= 1'b1;
            sweep_idx <= '0;
            ones_cnt  <= '0;
            zeros_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_SWEEP: begin
          if (tt[sweep_idx]) begin
            ones_cnt <= ones_cnt + CNT_ONE;
          end else begin
            zeros_cnt <= zeros_cnt + CNT_ONE;
          end
          sweep_idx <= sweep_idx + IDX_ONE;
          if (sweep_idx == IDX_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweep.sv
module tb_truth_table_sweep;

  logic clk = 1'b0;
  logic rst_n;

  // N_IN = 4 instance
  logic       load_en, load_bit, eval_valid, sweep_start;
  logic [3:0] eval_in;
  logic       t_valid, t_out, busy, done, tt_loaded;
  logic [4:0] ones_cnt, zeros_cnt;

  // N_IN = 3 instance
  logic       load_en3, load_bit3, eval_valid3, sweep_start3;
  logic [2:0] eval_in3;
  logic       t_valid3, t_out3, busy3, done3, tt_loaded3;
  logic [3:0] ones_cnt3, zeros_cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  truth_table_sweep #(.N_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_bit(load_bit),
    .eval_valid(eval_valid), .eval_in(eval_in), .t_valid(t_valid), .t_out(t_out),
    .sweep_start(sweep_start), .busy(busy), .done(done),
    .ones_cnt(ones_cnt), .zeros_cnt(zeros_cnt), .tt_loaded(tt_loaded)
  );

  truth_table_sweep #(.N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en3), .load_bit(load_bit3),
    .eval_valid(eval_valid3), .eval_in(eval_in3), .t_valid(t_valid3), .t_out(t_out3),
    .sweep_start(sweep_start3), .busy(busy3), .done(done3),
    .ones_cnt(ones_cnt3), .zeros_cnt(zeros_cnt3), .tt_loaded(tt_loaded3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then stable and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic b);
    load_en  = 1'b1;
    load_bit = b;
    step();
    load_en  = 1'b0;
  endtask

  // Watch n cycles and report whether busy or done ever rose.
  task automatic watch_quiet(input string tag, input int n);
    int seen_busy = 0;
    int seen_done = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (busy) seen_busy++;
      if (done) seen_done++;
    end
    check({tag, "_busy"}, seen_busy, 0);
    check({tag, "_done"}, seen_done, 0);
  endtask

  // Start a sweep; cyc ends as the sample index (1 = first sample after the
  // start edge) at which done was seen, nb counts samples with busy high.
  task automatic sweep4(input bit toggle, output int cyc, output int nb);
    sweep_start = 1'b1;
    load_en     = toggle;
    load_bit    = 1'b1;
    step();
    sweep_start = 1'b0;
    cyc = 1;
    nb  = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      if (toggle) load_en = ~load_en;
      step();
      cyc++;
    end
    load_en = 1'b0;
  endtask

  localparam logic [15:0] PATTERN = 16'h4644; // ones at 2,6,9,10,14
  localparam logic [7:0]  PAT3    = 8'hAA;

  initial begin
    int cyc, nb;
    logic [15:0] pat;
    logic [7:0]  pat3;
    pat  = PATTERN;
    pat3 = PAT3;

    rst_n = 1'b0;
    load_en = 0; load_bit = 0; eval_valid = 0; eval_in = '0; sweep_start = 0;
    load_en3 = 0; load_bit3 = 0; eval_valid3 = 0; eval_in3 = '0; sweep_start3 = 0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ones", ones_cnt, 0);
    check("rst_zeros", zeros_cnt, 0);
    check("rst_loaded", tt_loaded, 0);
    check("rst_tvalid", t_valid, 0);
    check("rst_tout", t_out, 0);
    rst_n = 1'b1;

    // Start before any load is ignored
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    watch_quiet("start_unloaded", 20);

    // 15 loads: still not accepted
    for (int i = 0; i < 15; i++) load4(pat[i]);
    check("loaded_after15", tt_loaded, 0);
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    watch_quiet("start_after15", 20);

    // 16th load completes the table
    load4(pat[15]);
    check("loaded_after16", tt_loaded, 1);

    sweep4(1'b0, cyc, nb);
    check("sweep1_done_cyc", cyc, 17);
    check("sweep1_busy_cycles", nb, 16);
    check("sweep1_busy_at_done", busy, 0);
    check("sweep1_ones", ones_cnt, 5);
    check("sweep1_zeros", zeros_cnt, 11);
    step();
    check("sweep1_done_pulse", done, 0);
    check("sweep1_ones_hold", ones_cnt, 5);
    check("sweep1_zeros_hold", zeros_cnt, 11);

    // Back-to-back evaluates
    eval_valid = 1'b1; eval_in = 4'b1001;
    step();
    check("eval9_valid", t_valid, 1);
    check("eval9_out", t_out, 1);
    eval_in = 4'b0011;
    step();
    check("eval3_valid", t_valid, 1);
    check("eval3_out", t_out, 0);
    eval_in = 4'd14;
    step();
    check("eval14_out", t_out, 1);
    eval_valid = 1'b0;
    step();
    check("evalidle_valid", t_valid, 0);
    check("evalidle_hold", t_out, 1);

    // Loads during a sweep (and alongside the start) are dropped; evaluate still runs
    eval_valid = 1'b1; eval_in = 4'd9;
    sweep4(1'b1, cyc, nb);
    eval_valid = 1'b0;
    check("sweep2_done_cyc", cyc, 17);
    check("sweep2_eval_out", t_out, 1);
    check("sweep2_ones", ones_cnt, 5);
    check("sweep2_zeros", zeros_cnt, 11);

    // Same-cycle load and evaluate of index 0 (pointer must still be 0)
    step();
    load_en = 1'b1; load_bit = 1'b1; eval_valid = 1'b1; eval_in = 4'd0;
    step();
    load_en = 1'b0;
    check("rw_same_old", t_out, 0);
    step();
    eval_valid = 1'b0;
    check("rw_same_new", t_out, 1);

    // Reset in the middle of a sweep
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int i = 1; i < 8; i++) step();
    check("midsweep_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rstsweep_busy", busy, 0);
    check("rstsweep_ones", ones_cnt, 0);
    check("rstsweep_zeros", zeros_cnt, 0);
    check("rstsweep_loaded", tt_loaded, 0);
    eval_valid = 1'b1; eval_in = 4'd9;
    step();
    eval_valid = 1'b0;
    check("rstsweep_eval_valid", t_valid, 1);
    check("rstsweep_eval_out", t_out, 0);

    // N_IN = 3 instance: alternating table
    for (int i = 0; i < 8; i++) begin
      load_en3 = 1'b1;
      load_bit3 = pat3[i];
      step();
    end
    load_en3 = 1'b0;
    check("n3_loaded", tt_loaded3, 1);
    sweep_start3 = 1'b1;
    step();
    sweep_start3 = 1'b0;
    cyc = 1;
    while (!done3 && cyc < 40) begin
      step();
      cyc++;
    end
    check("n3_done_cyc", cyc, 9);
    check("n3_ones", ones_cnt3, 4);
    check("n3_zeros", zeros_cnt3, 4);
    eval_valid3 = 1'b1; eval_in3 = 3'd5;
    step();
    eval_valid3 = 1'b0;
    check("n3_eval5", t_out3, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
